// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the boot-time
// instruction memory loader. The loader uses the slave modport; the
// stream source / RAM model uses the master modport.
interface instr_mem_loader_if #(
   parameter int ADDR_W = 16
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;

   // Stream source and RAM side.
   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

   // Loader side.
   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader.
// Accepts a byte stream (count_hi, count_lo, count x {word_hi, word_lo}),
// assembles big-endian 16-bit words and writes them to the instruction RAM
// at byte addresses 0, 2, 4, ... while holding the CPU in reset.
// Optional feature macro: INSTR_MEM_LOADER_CHECKSUM_EN adds a trailing
// checksum byte that must equal the XOR of every preceding stream byte.
module instr_mem_loader #(
   parameter int ADDR_W    = 16,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst,
   instr_mem_loader_if.slave bus,
   input  logic              start,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [15:0]       words_loaded
);

   typedef enum logic [2:0] {
      CNT_HI,
      CNT_LO,
      W_HI,
      W_LO,
      WRITE,
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      CHK,
`endif
      DONE,
      ERR
   } state_t;

   // Where the loader goes once the last word (or an empty image) is done.
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
   localparam state_t AFTER_LAST = CHK;
`else
   localparam state_t AFTER_LAST = DONE;
`endif

   // One extra bit so a header count of 0xFFFF compares cleanly.
   localparam logic [16:0] MAX_COUNT = 17'(MAX_WORDS);

   state_t            state;
   state_t            state_next;
   logic              armed;       // low only until the first clock after reset
   logic [15:0]       count;       // word count from the header
   logic [15:0]       wdata;       // word being assembled
   logic [ADDR_W-1:0] addr;        // byte address of the next write
   logic [15:0]       words;       // words written so far
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
   logic [7:0]        xor_acc;     // running XOR of accepted header/data bytes
`endif

   logic              ready_state;
   logic              xfer;
   logic              rearm;
   logic [15:0]       count_full;
   logic              last_word;

   // Byte acceptance happens only in the receiving states, and never in the
   // cycle right after reset release.
   always_comb begin
      // NOTE: every signal driven from a combinational block gets a default
      // first; a path that leaves it unassigned would infer a latch.
      ready_state = 1'b0;
      case (state)
         CNT_HI, CNT_LO, W_HI, W_LO: ready_state = 1'b1;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
         CHK:                        ready_state = 1'b1;
`endif
         default:                    ready_state = 1'b0;
      endcase
   end

   assign bus.in_ready = armed & ready_state;
   assign xfer         = bus.in_valid & bus.in_ready;
   assign rearm        = start & ((state == DONE) || (state == ERR));
   assign count_full   = {count[15:8], bus.in_data};
   assign last_word    = ((words + 16'd1) == count);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples the values from before the clock edge.
      if (rst) begin
         state <= CNT_HI;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decision from the current state and the accepted byte.
   always_comb begin
      state_next = state;
      case (state)
         CNT_HI: begin
            if (xfer) state_next = CNT_LO;
         end
         CNT_LO: begin
            if (xfer) begin
               if ({1'b0, count_full} > MAX_COUNT) begin
                  state_next = ERR;
               end else if (count_full == 16'd0) begin
                  state_next = AFTER_LAST;
               end else begin
                  state_next = W_HI;
               end
            end
         end
         W_HI: begin
            if (xfer) state_next = W_LO;
         end
         W_LO: begin
            if (xfer) state_next = WRITE;
         end
         WRITE: begin
            state_next = last_word ? AFTER_LAST : W_HI;
         end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
         CHK: begin
            if (xfer) state_next = (bus.in_data == xor_acc) ? DONE : ERR;
         end
`endif
         DONE, ERR: begin
            if (start) state_next = CNT_HI;
         end
         default: begin
            state_next = CNT_HI;
         end
      endcase
   end

   // Datapath: header count, word assembly, address/word counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed <= 1'b0;
         count <= '0;
         wdata <= '0;
         addr  <= '0;
         words <= '0;
      end else begin
         armed <= 1'b1;
         if (xfer) begin
            case (state)
               CNT_HI:  count[15:8] <= bus.in_data;
               CNT_LO:  count[7:0]  <= bus.in_data;
               W_HI:    wdata[15:8] <= bus.in_data;
               W_LO:    wdata[7:0]  <= bus.in_data;
               default: ;
            endcase
         end
         if (state == WRITE) begin
            words <= words + 16'd1;
            addr  <= addr + ADDR_W'(2);
         end
         if (rearm) begin
            words <= '0;
            addr  <= '0;
         end
      end
   end

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
   // Running XOR over every accepted byte before the checksum byte itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xor_acc <= '0;
      end else if (rearm) begin
         xor_acc <= '0;
      end else if (xfer && (state != CHK)) begin
         xor_acc <= xor_acc ^ bus.in_data;
      end
   end
`endif

   // Outputs decoded from state and the datapath registers.
   always_comb begin
      bus.mem_we    = (state == WRITE);
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
      cpu_hold      = (state != DONE);
      done          = (state == DONE);
      error         = (state == ERR);
      words_loaded  = words;
   end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Boot-time writer for the processor's instruction memory. It accepts a byte stream over a valid/ready interface and assembles big-endian 16-bit instruction words. Each word is written into a writable instruction RAM at consecutive even byte addresses (0, 2, 4, …), the same addressing the fetch stage uses with PC. It holds the CPU in reset until the image is fully loaded.

Parameters:
ADDR_W, 16, width of mem_addr; matches PC width.
MAX_WORDS, 256, largest word count accepted in the header; larger counts are rejected.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_data  input  8  stream byte.
in_valid  input  1  in_data valid this cycle.
in_ready  output  1  loader accepts the byte this cycle; a transfer happens when in_valid and in_ready are both high.
start  input  1  one-cycle pulse; re-arms the loader from DONE or ERR.
mem_we  output  1  instruction RAM write strobe, one cycle per word.
mem_addr  output  ADDR_W  byte address, always even.
mem_wdata  output  16  instruction word.
cpu_hold  output  1  keeps the CPU in reset while high.
done  output  1  load completed successfully; sticky.
error  output  1  load rejected; sticky.
words_loaded  output  16  count of words written so far.

Behaviour:
- Reset is asynchronous and active-high on rst; the block uses the single clock clk.
- Reset values: state CNT_HI, in_ready 0 until the first clock after reset release, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, done 0, error 0, words_loaded 0.
- Stream format: count_hi, count_lo, then count × (word_hi, word_lo), then a checksum byte only when the optional feature is enabled.
- States: CNT_HI, CNT_LO, W_HI, W_LO, WRITE, CHK, DONE, ERR.
- in_ready is 1 in CNT_HI, CNT_LO, W_HI, W_LO and CHK. It is 0 in WRITE, DONE and ERR.
- CNT_HI → CNT_LO on a byte transfer; the byte is latched as count[15:8].
- CNT_LO → next state on a byte transfer; the byte is latched as count[7:0]:
  - if count > MAX_WORDS → ERR;
  - if count == 0 → CHK when the feature is enabled, otherwise DONE;
  - else → W_HI.
- W_HI → W_LO on a byte transfer; the byte is latched into mem_wdata[15:8].
- W_LO → WRITE on a byte transfer; the byte is latched into mem_wdata[7:0].
- WRITE lasts exactly one cycle:
  - mem_we = 1, mem_addr = 2 × words_loaded, mem_wdata = assembled word;
  - on exit, words_loaded increments;
  - if words_loaded == count after the increment → CHK when the feature is enabled, otherwise DONE; else → W_HI.
- Latency: if the low byte is accepted at edge N, mem_we is high during cycle N+1 only. Peak rate is one word per 3 cycles.
- In states where in_ready is high, in_valid gaps simply stall; no timeout.
- mem_addr wraps modulo 2^ADDR_W. This cannot occur when MAX_WORDS ≤ 2^(ADDR_W-1).
- DONE: cpu_hold 0, done 1. Held until rst or start.
- ERR: cpu_hold 1, error 1. Held until rst or start.
- start in DONE or ERR: next state CNT_HI; done, error and words_loaded are cleared and cpu_hold returns to 1. start in any other state is ignored.
- rst mid-load aborts immediately to reset values. Words already written stay in RAM; there is no erase.
- Any bytes presented while in DONE or ERR are not accepted, because in_ready is 0.

Optional Feature:
INSTR_MEM_LOADER_CHECKSUM_EN
- Defined:
  - a running XOR is kept over every accepted byte, from count_hi through the last word_lo;
  - in CHK, one byte is accepted; it must equal the running XOR;
  - match → DONE, mismatch → ERR;
  - the running XOR clears on rst and on start.
- Not defined: CHK, the running XOR and the checksum byte do not exist. The transition from WRITE or CNT_LO goes directly to DONE.

Test Plan:
- Basic load, feature off: stream 00 02 31 80 62 00 → mem writes (addr 0x0000, 0x3180) then (0x0002, 0x6200), one mem_we cycle each. Then words_loaded=2, done=1, cpu_hold=0.
- Zero count: stream 00 00 → DONE with no mem_we pulse, words_loaded=0, done=1.
- Overflow: stream 01 01 (257 > 256) → ERR, error=1, cpu_hold=1, in_ready=0, no writes. A start pulse then re-arms to CNT_HI with error=0.
- Backpressure: the basic-load stream with in_valid deasserted for 5 cycles between every byte → identical writes and ordering. in_ready is 0 during each WRITE cycle and no byte is lost there.
- Reset mid-load: assert rst after 31 80 has been accepted and the first write is done → all outputs return to reset values. Reloading 00 01 AB CD writes (0x0000, 0xABCD).
- Checksum, feature on: stream 00 02 31 80 62 00 D1 → done=1. The same stream ending in D0 → error=1 and cpu_hold stays 1.
